// File: rtl/riscv_pkg.sv
// Shared pipeline types and constants for the 32-bit core front end.
// Carries the fetch queue entry layout used by if_fetch_unit and if_fetch_queue.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// In-order instruction queue between fetch and decode: synchronous FIFO of fetch_entry_t
// with a flush that empties it in one cycle. DEPTH must be a power of two, >= 2.
module if_fetch_queue
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               push_i,
  input  fetch_entry_t       push_data_i,
  input  logic               pop_i,
  output fetch_entry_t       head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [CNT_W-1:0]   count_o
);

  fetch_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone says which slots hold live data.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited word reads, drops
// wrong-path responses after a redirect and queues the rest for decode. FETCH_PERF_EN adds counters.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              Q_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]    id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped
`endif
);

  localparam int CNT_W = $clog2(Q_DEPTH) + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  exp_pc_q, exp_pc_d;
  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] q_count;
  logic             q_full, q_empty;
  fetch_entry_t     q_head;

  logic credit_ok, req_fire, rsp_seen, rsp_keep, deq;

  // Queued entries plus outstanding reads may never exceed the queue size.
  assign credit_ok      = ({1'b0, q_count} + {1'b0, in_flight_q}) < (CNT_W+1)'(Q_DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_seen       = imem_rsp_valid && (in_flight_q != '0);
  assign rsp_keep       = rsp_seen && (drop_cnt_q == '0) && !redirect_valid && !q_full;
  assign deq            = !q_empty && id_ready;

  // NOTE: always_comb uses blocking assignments with defaults first; state below uses <= only.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    exp_pc_d    = exp_pc_q;
    drop_cnt_d  = drop_cnt_q;
    in_flight_d = in_flight_q + CNT_W'(req_fire) - CNT_W'(rsp_seen);
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      exp_pc_d   = word_align(redirect_pc);
      drop_cnt_d = in_flight_q - CNT_W'(rsp_seen);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_keep) exp_pc_d   = exp_pc_q + PC_STEP;
      if (rsp_seen && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  // exp_pc_q is the PC of the oldest kept request: in-order returns make a FIFO of PCs redundant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      exp_pc_q    <= RESET_PC;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      exp_pc_q    <= exp_pc_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  if_fetch_queue #(.DEPTH(Q_DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (rsp_keep),
    .push_data_i ('{pc: exp_pc_q, instr: imem_rsp_data}),
    .pop_i       (deq),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  assign imem_addr = fetch_pc_q;
  assign id_valid  = !q_empty;
  assign id_instr  = q_empty ? '0 : q_head.instr;
  assign id_pc     = q_empty ? '0 : q_head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_dropped_q, dropped_inc;

  // A flush discards every queued entry except one that decode takes in the same cycle.
  always_comb begin
    dropped_inc = 32'(rsp_seen && !rsp_keep);
    if (redirect_valid) dropped_inc = dropped_inc + 32'(q_count) - 32'(deq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_q + 32'(rsp_keep);
      perf_dropped_q <= perf_dropped_q + dropped_inc;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`else
  // Counters absent in this build; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a one-cycle in-order memory model and a decode consumer
// that checks every handshake against the expected sequential / redirected PC stream.
module tb_if_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  if_fetch_unit #(.RESET_PC(32'h0), .Q_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pending[$];
  logic        rsp_en;
  logic [31:0] exp_id_pc, exp_req_addr, last_fire_addr;
  int          fire_cnt = 0;
  int          pop_cnt  = 0;
  int          p0, f0, guard;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then advance the memory model after it.
  task automatic tick();
    logic        fire, rsp;
    logic [31:0] a;
    #1;
    fire = imem_req_valid && imem_req_ready;
    a    = imem_addr;
    rsp  = imem_rsp_valid;
    if (fire) begin
      check("req_addr", a, exp_req_addr);
      exp_req_addr   = exp_req_addr + 32'd4;
      last_fire_addr = a;
      fire_cnt++;
    end
    if (id_valid && id_ready) begin
      check("id_pc", id_pc, exp_id_pc);
      check("id_instr", id_instr, mem_word(exp_id_pc));
      exp_id_pc = exp_id_pc + 32'd4;
      pop_cnt++;
    end
    if (redirect_valid) begin
      exp_id_pc    = {redirect_pc[31:2], 2'b00};
      exp_req_addr = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    if (rsp && pending.size() > 0) void'(pending.pop_front());
    if (fire) pending.push_back(a);
    imem_rsp_valid = rsp_en && (pending.size() > 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(pending[0]) : 32'h0;
  endtask

  task automatic wait_id_valid(input string tag);
    int i;
    i = 0;
    while (!id_valid && i < 20) begin
      tick();
      i++;
    end
    check(tag, 32'(id_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    check({tag, "_imem_addr"}, imem_addr, 32'h0);
    check({tag, "_id_instr"}, id_instr, 32'h0);
    check({tag, "_id_pc"}, id_pc, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0; rsp_en = 1'b1;
    exp_id_pc = 32'h0; exp_req_addr = 32'h0; last_fire_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    // 1: sequential fetch from reset, best-case latency, 3 cycles per 2 instructions.
    imem_req_ready = 1'b1; id_ready = 1'b1; rst = 1'b0;
    #1;
    check("t1_req_valid", 32'(imem_req_valid), 32'd1);
    p0 = pop_cnt;
    tick();
    check("t1_no_bypass", 32'(id_valid), 32'd0);
    tick();
    check("t1_id_valid", 32'(id_valid), 32'd1);
    check("t1_id_pc", id_pc, 32'h0);
    repeat (6) tick();
    check("t1_pops", 32'(pop_cnt - p0), 32'd4);

    // 2: decode stalls; exactly Q_DEPTH entries collect and requests stop.
    id_ready = 1'b0;
    repeat (10) tick();
    check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
    check("t2_id_valid", 32'(id_valid), 32'd1);
    imem_req_ready = 1'b0; id_ready = 1'b1; p0 = pop_cnt;
    repeat (4) tick();
    check("t2_entries", 32'(pop_cnt - p0), 32'd2);
    check("t2_empty", 32'(id_valid), 32'd0);

    // 3: memory back-pressure holds the address.
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_addr_held", imem_addr, 32'h10);
      check("t3_req_valid", 32'(imem_req_valid), 32'd1);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("t3_addr_next", imem_addr, 32'h14);
    repeat (4) tick();

    // 4: redirect with two reads outstanding; both stale responses must vanish.
    rsp_en = 1'b0; imem_req_ready = 1'b1;
    tick();
    tick();
    check("t4_credit", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0; rsp_en = 1'b1;
    #1;
    check("t4_addr", imem_addr, 32'h200);
    wait_id_valid("t4_first_valid");
    check("t4_first_pc", id_pc, 32'h200);
    repeat (4) tick();

    // 5: redirect coincides with a response and a decode handshake.
    imem_req_ready = 1'b0;
    repeat (6) tick();
    check("t5_drained", 32'(id_valid), 32'd0);
    id_ready = 1'b0; imem_req_ready = 1'b1;
    tick();
    tick();
    check("t5_pre_valid", 32'(id_valid), 32'd1);
    check("t5_credit", 32'(imem_req_valid), 32'd0);
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t5_flushed", 32'(id_valid), 32'd0);
    check("t5_req_valid", 32'(imem_req_valid), 32'd1);
    check("t5_addr", imem_addr, 32'h300);
    wait_id_valid("t5_first_valid");
    check("t5_first_pc", id_pc, 32'h300);

    // 6: fetch address wraps past the top of memory, then async reset mid-stream.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    f0 = fire_cnt; guard = 0;
    while (fire_cnt - f0 < 2 && guard < 20) begin
      tick();
      guard++;
    end
    check("t6_wrap_fires", 32'(fire_cnt - f0), 32'd2);
    check("t6_wrap_addr", last_fire_addr, 32'h0);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    pending.delete();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    exp_id_pc = 32'h0; exp_req_addr = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0; p0 = pop_cnt;
    repeat (8) tick();
    check("t6_restart_pops", 32'(pop_cnt - p0), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
